dual_issue_router: RTL



---
 rtl/spu_isa_pkg.sv | 56 +++++
 rtl/inst_field_decode.sv | 30 +++
 rtl/dual_issue_router.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spu_isa_pkg.sv
// SPU ISA definitions shared by the dual-issue decode stage.
// Opcode map, pipe classes, field layout and the decoded bundle.
package spu_isa_pkg;

  localparam int OPC_W  = 6;
  localparam int REG_W  = 7;
  localparam int IMMF_W = 10;

  localparam int RD_LSB  = 0;
  localparam int RA_LSB  = 7;
  localparam int RB_LSB  = 14;
  localparam int IMM_LSB = 14;

  localparam logic [31:0] NOP_INST = 32'hffff_ffff;

  typedef enum logic [OPC_W-1:0] {
    ADDHW  = 6'd4,
    ADDHWI = 6'd6,
    ADDW   = 6'd8,
    ADDWI  = 6'd10,
    MULW   = 6'd20,
    NOP_OP = 6'd63
  } opcode_e;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_e;

  typedef struct packed {
    logic [OPC_W-1:0]  op;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rd;
    logic [IMMF_W-1:0] imm;
    logic              imm_sel;
  } bundle_t;

  localparam int BND_W = $bits(bundle_t);

  // Odd pipe has no immediate select; same field order minus the LSB.
  typedef struct packed {
    logic [OPC_W-1:0]  op;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rd;
    logic [IMMF_W-1:0] imm;
  } odd_bundle_t;

  function automatic logic is_imm_op(
    input logic [OPC_W-1:0] op
  );
    return (op == ADDHWI) || (op == ADDWI);
  endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Per-slot field decode: pipe class, control bundle and NOP flag.
// Purely combinational; one instance per pair slot.
module inst_field_decode
  import spu_isa_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic [INST_W-1:0] inst,
  output pipe_e             cls,
  output bundle_t           bnd,
  output logic              nop
);

  logic [OPC_W-1:0] op;

  assign op  = inst[INST_W-1 -: OPC_W];
  assign nop = &inst;
  assign cls = op[0] ? PIPE_ODD : PIPE_EVEN;

  always_comb begin
    bnd         = '0;
    bnd.op      = op;
    bnd.rd      = inst[RD_LSB +: REG_W];
    bnd.ra      = inst[RA_LSB +: REG_W];
    bnd.rb      = inst[RB_LSB +: REG_W];
    bnd.imm     = inst[IMM_LSB +: IMMF_W];
    bnd.imm_sel = is_imm_op(op);
  end

endmodule

// File: rtl/dual_issue_router.sv
// Dual-issue decode/route stage: splits fetch pairs into even/odd bundles.
// Define PAIR_RAW_CHECK_EN to also split pairs with an intra-pair RAW.
module dual_issue_router
  import spu_isa_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int OP_W      = 6,
  parameter int IMM_W     = 10,
  parameter int MUL_STALL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [2*INST_W-1:0] in_pair,
  output logic                in_ready,
  input  logic                flush,
  output logic                even_valid,
  output logic [OP_W-1:0]     even_op,
  output logic [ADDR_W-1:0]   even_ra,
  output logic [ADDR_W-1:0]   even_rb,
  output logic [ADDR_W-1:0]   even_rd,
  output logic [IMM_W-1:0]    even_imm,
  output logic                even_imm_sel,
  output logic                odd_valid,
  output logic [OP_W-1:0]     odd_op,
  output logic [ADDR_W-1:0]   odd_ra,
  output logic [ADDR_W-1:0]   odd_rb,
  output logic [ADDR_W-1:0]   odd_rd,
  output logic [IMM_W-1:0]    odd_imm
);

  localparam int CNT_W =
    (MUL_STALL < 2) ? 1 : $clog2(MUL_STALL + 1);
  localparam bit STALL_EN = (MUL_STALL > 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e state_q, state_d;

  bundle_t     hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  bundle_t     ev_q, ev_d;
  odd_bundle_t od_q, od_d;
  logic        evv_q, evv_d;
  logic        odv_q, odv_d;

  pipe_e   cls0, cls1;
  bundle_t b0, b1;
  logic    nop0, nop1;
  logic    raw, split;
  logic    iss0, iss1, issh, latch, mul_hit;

  inst_field_decode #(.INST_W(INST_W)) u_dec0 (
    .inst (in_pair[INST_W-1:0]),
    .cls  (cls0),
    .bnd  (b0),
    .nop  (nop0)
  );

  inst_field_decode #(.INST_W(INST_W)) u_dec1 (
    .inst (in_pair[2*INST_W-1:INST_W]),
    .cls  (cls1),
    .bnd  (b1),
    .nop  (nop1)
  );

`ifdef PAIR_RAW_CHECK_EN
  assign raw = (b1.ra == b0.rd) ||
               (!b1.imm_sel && (b1.rb == b0.rd));
`else
  assign raw = 1'b0;
`endif

  assign split    = (cls0 == cls1) || raw;
  assign in_ready = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;
    iss0       = 1'b0;
    iss1       = 1'b0;
    issh       = 1'b0;
    latch      = 1'b0;
    mul_hit    = 1'b0;
    if (flush) begin
      state_d    = RUN;
      hold_d     = '0;
      hold_vld_d = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (in_valid) begin
            iss0  = !nop0;
            iss1  = !nop1 && (nop0 || !split);
            latch = !nop0 && !nop1 && split;
          end
          if (latch) begin
            hold_d     = b1;
            hold_vld_d = 1'b1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          issh       = hold_vld_q;
          hold_vld_d = 1'b0;
          state_d    = RUN;
        end
        STALL: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1))
            state_d = hold_vld_q ? HOLD : RUN;
        end
        default: state_d = RUN;
      endcase
      mul_hit = (iss0 && (b0.op == MULW)) ||
                (iss1 && (b1.op == MULW)) ||
                (issh && (hold_q.op == MULW));
      // A pending hold survives the stall and drains on exit.
      if (STALL_EN && mul_hit) begin
        cnt_d   = CNT_W'(MUL_STALL);
        state_d = STALL;
      end
    end
  end

  always_comb begin
    ev_d  = '0;
    od_d  = '0;
    evv_d = 1'b0;
    odv_d = 1'b0;
    if (iss0) begin
      if (cls0 == PIPE_EVEN) begin
        ev_d  = b0;
        evv_d = 1'b1;
      end else begin
        od_d  = b0[BND_W-1:1];
        odv_d = 1'b1;
      end
    end
    if (iss1) begin
      if (cls1 == PIPE_EVEN) begin
        ev_d  = b1;
        evv_d = 1'b1;
      end else begin
        od_d  = b1[BND_W-1:1];
        odv_d = 1'b1;
      end
    end
    if (issh) begin
      if (!hold_q.op[0]) begin
        ev_d  = hold_q;
        evv_d = 1'b1;
      end else begin
        od_d  = hold_q[BND_W-1:1];
        odv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      cnt_q      <= '0;
      ev_q       <= '0;
      od_q       <= '0;
      evv_q      <= 1'b0;
      odv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      cnt_q      <= cnt_d;
      ev_q       <= ev_d;
      od_q       <= od_d;
      evv_q      <= evv_d;
      odv_q      <= odv_d;
    end
  end

  assign even_valid   = evv_q;
  assign even_op      = OP_W'(ev_q.op);
  assign even_ra      = ADDR_W'(ev_q.ra);
  assign even_rb      = ADDR_W'(ev_q.rb);
  assign even_rd      = ADDR_W'(ev_q.rd);
  assign even_imm     = IMM_W'(ev_q.imm);
  assign even_imm_sel = ev_q.imm_sel;

  assign odd_valid    = odv_q;
  assign odd_op       = OP_W'(od_q.op);
  assign odd_ra       = ADDR_W'(od_q.ra);
  assign odd_rb       = ADDR_W'(od_q.rb);
  assign odd_rd       = ADDR_W'(od_q.rd);
  assign odd_imm      = IMM_W'(od_q.imm);

endmodule
